wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Writeback trace buffer for the pipelined datapath. It observes the write-back stage's register-file write port and records every architecturally visible write (register, data, cycle timestamp) into a first-word-fall-through FIFO. A downstream reader drains the FIFO with a valid/pop handshake; this is either the board display/UART logic or a bench-side checker. The datapath is the writer of trace events and this block is their reader/store, so results are checked against the full write stream rather than against a single ALU output.

## Interface
- DEPTH, 8, number of FIFO entries; power of two, at least 2
- TS_WIDTH, 16, width of the free-running cycle timestamp
- Clk  in  1  rising-edge clock shared with the datapath
- Reset  in  1  asynchronous, active-low reset; all state clears while low
- RegWrite  in  1  WB-stage register-file write enable
- WriteReg  in  5  WB-stage destination register number
- WriteData  in  32  WB-stage write data
- CaptureEn  in  1  global capture enable; 0 suppresses new captures
- PopReq  in  1  reader removes the head entry at the next edge
- ClearOvf  in  1  clears Overflow and DropCount
- EntryValid  out  1  head entry present
- EntryReg  out  5  head entry register number; 0 when EntryValid=0
- EntryData  out  32  head entry data; 0 when EntryValid=0
- EntryTime  out  TS_WIDTH  head entry timestamp; 0 when EntryValid=0
- Count  out  log2(DEPTH)+1  number of stored entries
- Overflow  out  1  sticky flag: at least one capture was dropped
- DropCount  out  8  dropped captures, saturating at 255

## Operation
- Timestamp counter TS:
  - 0 while Reset is low.
  - Increments by 1 every Clk edge after release.
  - Wraps modulo 2^TS_WIDTH.
- Capture condition, evaluated every cycle: RegWrite=1 and CaptureEn=1 and WriteReg!=0. Writes to $zero are never recorded.
- Stored entry: {WriteReg, WriteData, TS value in the capture cycle}.
- Storage: circular buffer with read and write pointers of log2(DEPTH) bits, wrapping at DEPTH-1 to 0. Count tracks full and empty.
- Pop: a pop occurs when PopReq=1 and EntryValid=1. PopReq with EntryValid=0 is ignored, with no underflow and no state change.
- Push when not full: entry written at the write pointer; Count+1.
- Push when full:
  - If a pop occurs in the same cycle, both happen and Count stays DEPTH.
  - Otherwise the capture is dropped: Overflow<=1 and DropCount<=min(DropCount+1, 255).
- Simultaneous push and pop when not full: both happen; Count unchanged.
- Simultaneous push and pop when empty: the pop is ignored (EntryValid=0) and the push happens.
- ClearOvf=1: Overflow<=0 and DropCount<=0. If a drop occurs in the same cycle, the drop wins: Overflow<=1, DropCount<=1.
- CaptureEn affects only new captures. Stored entries remain and remain poppable.
- Reset asserted mid-operation: all entries are discarded immediately, pointers and Count go to 0, flags clear, and TS returns to 0.

## Timing
- Reset values: EntryValid=0, EntryReg=0, EntryData=0, EntryTime=0, Count=0, Overflow=0, DropCount=0.
- Capture-to-visible latency is 1 cycle. A capture sampled at edge N gives EntryValid=1 with that entry's data after edge N when the FIFO was empty.
- Entry* outputs are registered or driven from storage at the read pointer (FWFT). A new head appears in the cycle after the pop edge.
- Count, Overflow and DropCount update at the same edge as the push, pop or drop that changes them.
- TS value recorded: the first cycle after Reset release records TS=0, the next TS=1, and so on.
- No combinational path from PopReq to Entry* outputs.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- **Reset and basic capture.** Hold Reset low 3 cycles, release. In cycle 2 apply RegWrite=1, WriteReg=8, WriteData=0x0000_0005. Required: EntryValid=1 next cycle with EntryReg=8, EntryData=5, EntryTime=2, Count=1. Pop gives EntryValid=0 and Count=0.
- **Filtering.** WriteReg=0 with RegWrite=1, then RegWrite=0 with WriteReg=9, then CaptureEn=0 with a valid write. Required: Count stays 0 and EntryValid stays 0 throughout.
- **Fill and overflow.** DEPTH=8. Push 8 writes with data 1..8, then 3 more without popping. Required: Count=8, Overflow=1, DropCount=3. Draining yields data 1..8 in order with ascending timestamps, then EntryValid=0.
- **Full with simultaneous push/pop.** With Count=8, push data 0xAA and pop in the same cycle. Required: Count=8, Overflow unchanged, head advances, and 0xAA is the last entry read on drain.
- **Clear vs drop race.** With Overflow=1 and DropCount=3 and FIFO full, assert ClearOvf together with a dropped capture. Required: Overflow=1, DropCount=1. Then ClearOvf alone gives 0 and 0.
- **Reset mid-stream.** With Count=5, assert Reset low for one cycle between edges. Required: EntryValid, Count, Overflow, DropCount and TS go to 0 immediately. After release, the first capture carries EntryTime=0.

Source files
------------

// File: rtl/wb_trace_fifo_if.sv
// Bus between the write-back stage / trace reader and the trace FIFO.
// slave = the FIFO side, master = datapath plus reader side.
interface wb_trace_fifo_if #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                RegWrite;
  logic [4:0]          WriteReg;
  logic [31:0]         WriteData;
  logic                CaptureEn;
  logic                PopReq;
  logic                ClearOvf;
  logic                EntryValid;
  logic [4:0]          EntryReg;
  logic [31:0]         EntryData;
  logic [TS_WIDTH-1:0] EntryTime;
  logic [CW-1:0]       Count;
  logic                Overflow;
  logic [7:0]          DropCount;

  modport master (
    output RegWrite, WriteReg, WriteData, CaptureEn, PopReq, ClearOvf,
    input  EntryValid, EntryReg, EntryData, EntryTime, Count, Overflow, DropCount
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, CaptureEn, PopReq, ClearOvf,
    output EntryValid, EntryReg, EntryData, EntryTime, Count, Overflow, DropCount
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Write-back trace buffer: records register-file writes with a cycle
// timestamp into a first-word-fall-through FIFO drained by valid/pop.
module wb_trace_fifo #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  wb_trace_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]          reg_num;
    logic [31:0]         data;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic empty, full, capture, do_pop, do_push, do_drop;
  entry_t head;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    capture = bus.RegWrite && bus.CaptureEn && (bus.WriteReg != 5'd0);
    do_pop  = bus.PopReq && !empty;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    do_push = capture && (!full || do_pop);
    do_drop = capture && full && !do_pop;

    ts_d     = ts_q + TS_WIDTH'(1);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);

    // A drop in the same cycle as a clear leaves exactly that one drop recorded.
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (do_drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = bus.ClearOvf ? 8'd1
                 : (drop_cnt_q == 8'd255) ? 8'd255 : drop_cnt_q + 8'd1;
    end else if (bus.ClearOvf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the outputs are masked whenever Count is 0.
  always_ff @(posedge Clk) begin
    if (Reset && do_push) begin
      mem_q[wr_ptr_q] <= '{reg_num: bus.WriteReg, data: bus.WriteData, ts: ts_q};
    end
  end

  always_comb begin
    head           = mem_q[rd_ptr_q];
    bus.EntryValid = !empty;
    bus.EntryReg   = empty ? 5'd0  : head.reg_num;
    bus.EntryData  = empty ? 32'd0 : head.data;
    bus.EntryTime  = empty ? '0    : head.ts;
    bus.Count      = count_q;
    bus.Overflow   = ovf_q;
    bus.DropCount  = drop_cnt_q;
  end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_wb_trace_fifo;
  localparam int DEPTH    = 8;
  localparam int TS_WIDTH = 16;

  logic clk;
  logic rst_n;

  wb_trace_fifo_if #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) bus ();

  wb_trace_fifo #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned r;
    int unsigned d;
    int unsigned t;
  } ent_t;

  ent_t        q[$];
  int unsigned m_ts;
  int unsigned m_dc;
  bit          m_ovf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit rw, input int unsigned wr, input int unsigned wd,
                       input bit ce, input bit pr, input bit clr);
    bus.RegWrite  = rw;
    bus.WriteReg  = 5'(wr);
    bus.WriteData = wd;
    bus.CaptureEn = ce;
    bus.PopReq    = pr;
    bus.ClearOvf  = clr;
  endtask

  task automatic model_reset();
    q.delete();
    m_ts  = 0;
    m_dc  = 0;
    m_ovf = 1'b0;
  endtask

  // Reference behaviour of one clock edge, from the FIFO rules.
  task automatic model_edge();
    bit   cap, popped, was_full, drop;
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cap      = bus.RegWrite && bus.CaptureEn && (bus.WriteReg != 0);
    was_full = (q.size() == DEPTH);
    popped   = bus.PopReq && (q.size() > 0);
    drop     = cap && was_full && !popped;
    if (popped) void'(q.pop_front());
    if (cap && !drop) begin
      e.r = bus.WriteReg;
      e.d = bus.WriteData;
      e.t = m_ts;
      q.push_back(e);
    end
    if (drop) begin
      m_ovf = 1'b1;
      m_dc  = bus.ClearOvf ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
    end else if (bus.ClearOvf) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
    m_ts = (m_ts + 1) % (1 << TS_WIDTH);
  endtask

  task automatic compare_all(input string tag);
    bit v;
    v = (q.size() > 0);
    check({tag, ".valid"}, 64'(bus.EntryValid), 64'(v));
    check({tag, ".reg"},   64'(bus.EntryReg),   v ? 64'(q[0].r) : 64'd0);
    check({tag, ".data"},  64'(bus.EntryData),  v ? 64'(q[0].d) : 64'd0);
    check({tag, ".time"},  64'(bus.EntryTime),  v ? 64'(q[0].t) : 64'd0);
    check({tag, ".count"}, 64'(bus.Count),      64'(q.size()));
    check({tag, ".ovf"},   64'(bus.Overflow),   64'(m_ovf));
    check({tag, ".drops"}, 64'(bus.DropCount),  64'(m_dc));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] last;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 0, 0);

    // Reset and basic capture
    repeat (3) step("reset");
    check("reset_valid", 64'(bus.EntryValid), 64'd0);
    check("reset_count", 64'(bus.Count), 64'd0);
    rst_n = 1'b1;
    step("idle0");
    step("idle1");
    drive(1, 8, 32'h5, 1, 0, 0);
    step("basic");
    check("basic_valid", 64'(bus.EntryValid), 64'd1);
    check("basic_reg",   64'(bus.EntryReg),   64'd8);
    check("basic_data",  64'(bus.EntryData),  64'd5);
    check("basic_time",  64'(bus.EntryTime),  64'd2);
    check("basic_count", 64'(bus.Count),      64'd1);
    drive(0, 0, 0, 1, 1, 0);
    step("basic_pop");
    check("basic_pop_valid", 64'(bus.EntryValid), 64'd0);
    check("basic_pop_count", 64'(bus.Count),      64'd0);

    // Filtering: $zero, no RegWrite, capture disabled; pop while empty is ignored
    drive(1, 0, 32'h11, 1, 1, 0);
    step("filt_zero");
    check("filt_zero_count", 64'(bus.Count), 64'd0);
    drive(0, 9, 32'h22, 1, 0, 0);
    step("filt_norw");
    check("filt_norw_valid", 64'(bus.EntryValid), 64'd0);
    drive(1, 9, 32'h33, 0, 0, 0);
    step("filt_noce");
    check("filt_noce_count", 64'(bus.Count), 64'd0);

    // Fill and overflow
    for (int i = 1; i <= 8; i++) begin
      drive(1, i + 1, i, 1, 0, 0);
      step("fill");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 20, 100 + i, 1, 0, 0);
      step("over");
    end
    drive(0, 0, 0, 1, 0, 0);
    step("full_idle");
    check("full_count", 64'(bus.Count),     64'd8);
    check("full_ovf",   64'(bus.Overflow),  64'd1);
    check("full_drops", 64'(bus.DropCount), 64'd3);
    check("full_head",  64'(bus.EntryData), 64'd1);

    // Full with simultaneous push and pop
    drive(1, 5, 32'hAA, 1, 1, 0);
    step("full_pp");
    check("full_pp_count", 64'(bus.Count),     64'd8);
    check("full_pp_ovf",   64'(bus.Overflow),  64'd1);
    check("full_pp_drops", 64'(bus.DropCount), 64'd3);
    check("full_pp_head",  64'(bus.EntryData), 64'd2);

    // Clear racing a drop, then clear alone
    drive(1, 6, 32'hBB, 1, 0, 1);
    step("clr_race");
    check("clr_race_ovf",   64'(bus.Overflow),  64'd1);
    check("clr_race_drops", 64'(bus.DropCount), 64'd1);
    drive(0, 0, 0, 1, 0, 1);
    step("clr_alone");
    check("clr_alone_ovf",   64'(bus.Overflow),  64'd0);
    check("clr_alone_drops", 64'(bus.DropCount), 64'd0);

    // Drain: 2..8 then 0xAA last
    last = '0;
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      last = bus.EntryData;
      step("drain");
    end
    check("drain_last",  64'(last),           64'hAA);
    check("drain_valid", 64'(bus.EntryValid), 64'd0);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) begin
      drive(1, 10 + i, 32'h500 + i, 1, 0, 0);
      step("mid_fill");
    end
    check("mid_count5", 64'(bus.Count), 64'd5);
    drive(0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all("mid_rst");
    check("mid_rst_valid", 64'(bus.EntryValid), 64'd0);
    check("mid_rst_count", 64'(bus.Count),      64'd0);
    #1;
    rst_n = 1'b1;
    drive(1, 3, 32'h77, 1, 0, 0);
    step("post_rst");
    check("post_rst_time",  64'(bus.EntryTime), 64'd0);
    check("post_rst_count", 64'(bus.Count),     64'd1);

    // Random traffic, pop bias alternating so the FIFO both fills and drains
    for (int i = 0; i < 3000; i++) begin
      int unsigned pop_bias;
      pop_bias = ((i / 300) % 2 == 0) ? 3 : 1;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom,
            $urandom_range(0, 7) != 0, $urandom_range(0, pop_bias) == 0,
            $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all("rnd_rst");
        #1;
        rst_n = 1'b1;
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
